// File: rtl/mem_region_bus_pkg.sv
// rtl/mem_region_bus_pkg.sv - shared types, default region map and decode helper for mem_region_bus
package mem_region_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SRAM_RD  = 3'd1,
        ST_PER_REQ  = 3'd2,
        ST_PER_WAIT = 3'd3,
        ST_RSP      = 3'd4
    } state_e;

    localparam logic [63:0] DEF_SRAM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEF_SRAM_MASK = 64'h0000_0000_0FFF_FFFF;
    localparam logic [63:0] DEF_PER_BASE  = 64'h0000_0000_9000_0000;
    localparam logic [63:0] DEF_PER_MASK  = 64'h0000_0000_0FFF_FFFF;

    // Mask bits are "don't care" offset bits inside the region.
    function automatic logic region_hit(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] mask);
        return (addr | mask) == (base | mask);
    endfunction

endpackage

// File: rtl/gen_dffr.sv
// rtl/gen_dffr.sv - register with asynchronous active-low reset to zero
module gen_dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/gen_dffren.sv
// rtl/gen_dffren.sv - load-enabled register with asynchronous active-low reset to zero
module gen_dffren #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gen_sram.sv
// rtl/gen_sram.sv - single-port byte-writable SRAM with registered read data
module gen_sram #(
    parameter int DW = 64,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            en,
    input  logic [DW/8-1:0] wstrb,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read returns the pre-write contents when reading and writing the same row.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DW/8; i++) begin
                if (wstrb[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bank_align.sv
// rtl/mem_bank_align.sv - combinational even/odd bank split for writes and realignment for reads
module mem_bank_align #(
    parameter int DW      = 64,
    parameter int SRAM_AW = 11
) (
    input  logic [$clog2(DW/8)+SRAM_AW:0] addr,
    input  logic [DW-1:0]                 data_w,
    input  logic [DW/8-1:0]               wstrb,
    input  logic                          wen,
    output logic [SRAM_AW-1:0]            even_row,
    output logic [SRAM_AW-1:0]            odd_row,
    output logic [DW-1:0]                 even_wdata,
    output logic [DW-1:0]                 odd_wdata,
    output logic [DW/8-1:0]               even_wstrb,
    output logic [DW/8-1:0]               odd_wstrb,
    input  logic                          rd_bsel,
    input  logic [$clog2(DW/8)-1:0]       rd_off,
    input  logic [DW-1:0]                 even_rdata,
    input  logic [DW-1:0]                 odd_rdata,
    output logic [DW-1:0]                 rdata
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    logic               bsel;
    logic [OW-1:0]      off;
    logic [SRAM_AW-1:0] row;
    logic [SRAM_AW-1:0] row_inc;
    logic [2*DW-1:0]    wide_data;
    logic [2*BW-1:0]    wide_strb;
    logic [2*DW-1:0]    wide_rd;

    assign off     = addr[OW-1:0];
    assign bsel    = addr[OW];
    assign row     = addr[OW+1 +: SRAM_AW];
    assign row_inc = row + {{(SRAM_AW-1){1'b0}}, 1'b1};

    assign wide_data = {{DW{1'b0}}, data_w} << {off, 3'b000};
    assign wide_strb = {{BW{1'b0}}, wstrb & {BW{wen}}} << off;

    // Low half always lands in the addressed bank; the spill-over goes to the other one.
    always_comb begin
        even_row   = row;
        odd_row    = row;
        even_wdata = wide_data[DW-1:0];
        odd_wdata  = wide_data[2*DW-1:DW];
        even_wstrb = wide_strb[BW-1:0];
        odd_wstrb  = wide_strb[2*BW-1:BW];
        if (bsel) begin
            even_row   = row_inc;
            odd_wdata  = wide_data[DW-1:0];
            even_wdata = wide_data[2*DW-1:DW];
            odd_wstrb  = wide_strb[BW-1:0];
            even_wstrb = wide_strb[2*BW-1:BW];
        end
    end

    assign wide_rd = rd_bsel ? {even_rdata, odd_rdata} : {odd_rdata, even_rdata};
    assign rdata   = DW'(wide_rd >> {rd_off, 3'b000});

endmodule

// File: rtl/mem_region_bus.sv
// rtl/mem_region_bus.sv - LSU memory port decoder onto two-bank SRAM, peripheral fabric or error
module mem_region_bus
    import mem_region_bus_pkg::*;
#(
    parameter int          DW        = 64,
    parameter int          SRAM_AW   = 11,
    parameter logic [63:0] SRAM_BASE = DEF_SRAM_BASE,
    parameter logic [63:0] SRAM_MASK = DEF_SRAM_MASK,
    parameter logic [63:0] PER_BASE  = DEF_PER_BASE,
    parameter logic [63:0] PER_MASK  = DEF_PER_MASK
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            mem_mstReq_valid,
    output logic            mem_mstReq_ready,
    input  logic [63:0]     mem_addr,
    input  logic [DW-1:0]   mem_data_w,
    input  logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_wen,
    output logic            mem_slvRsp_valid,
    input  logic            mem_slvRsp_ready,
    output logic [DW-1:0]   mem_data_r,
    output logic            mem_slvRsp_err,
    output logic            per_req_valid,
    input  logic            per_req_ready,
    output logic [63:0]     per_addr,
    output logic [DW-1:0]   per_data_w,
    output logic [DW/8-1:0] per_wstrb,
    output logic            per_wen,
    input  logic            per_rsp_valid,
    input  logic [DW-1:0]   per_data_r,
    input  logic            per_rsp_err
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    state_e          state_q;
    state_e          state_d;
    logic [2:0]      state_raw;
    logic            is_sram;
    logic            is_per;
    logic            req_hs;
    logic            bank_en;
    logic            per_ld;
    logic            rsp_ld;
    logic [DW-1:0]   rsp_data_d;
    logic            rsp_err_d;
    logic [OW+1:0]   rd_ctx_q;
    logic            rd_wen_q;
    logic            rd_bsel_q;
    logic [OW-1:0]   rd_off_q;

    logic [SRAM_AW-1:0] even_row;
    logic [SRAM_AW-1:0] odd_row;
    logic [DW-1:0]      even_wdata;
    logic [DW-1:0]      odd_wdata;
    logic [BW-1:0]      even_wstrb;
    logic [BW-1:0]      odd_wstrb;
    logic [DW-1:0]      even_rdata;
    logic [DW-1:0]      odd_rdata;
    logic [DW-1:0]      align_rdata;

    assign is_sram = region_hit(mem_addr, SRAM_BASE, SRAM_MASK);
    assign is_per  = region_hit(mem_addr, PER_BASE, PER_MASK);
    assign req_hs  = mem_mstReq_valid && (state_q == ST_IDLE);
    assign bank_en = req_hs && is_sram;
    assign per_ld  = req_hs && !is_sram && is_per;

    gen_dffr #(.W(3)) u_state (
        .clk   (CLK),
        .rst_n (RSTn),
        .d     (state_d),
        .q     (state_raw)
    );
    assign state_q = state_e'(state_raw);

    // Offset and bank select must outlive the request to realign the next-cycle read data.
    gen_dffren #(.W(OW+2)) u_rd_ctx (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (bank_en),
        .d     ({mem_wen, mem_addr[OW:0]}),
        .q     (rd_ctx_q)
    );
    assign rd_wen_q  = rd_ctx_q[OW+1];
    assign rd_bsel_q = rd_ctx_q[OW];
    assign rd_off_q  = rd_ctx_q[OW-1:0];

    gen_dffren #(.W(64)) u_per_addr (
        .clk(CLK), .rst_n(RSTn), .en(per_ld), .d(mem_addr), .q(per_addr)
    );
    gen_dffren #(.W(DW)) u_per_data (
        .clk(CLK), .rst_n(RSTn), .en(per_ld), .d(mem_data_w), .q(per_data_w)
    );
    gen_dffren #(.W(BW)) u_per_strb (
        .clk(CLK), .rst_n(RSTn), .en(per_ld), .d(mem_wstrb), .q(per_wstrb)
    );
    gen_dffren #(.W(1)) u_per_wen (
        .clk(CLK), .rst_n(RSTn), .en(per_ld), .d(mem_wen), .q(per_wen)
    );

    gen_dffren #(.W(DW)) u_rsp_data (
        .clk(CLK), .rst_n(RSTn), .en(rsp_ld), .d(rsp_data_d), .q(mem_data_r)
    );
    gen_dffren #(.W(1)) u_rsp_err (
        .clk(CLK), .rst_n(RSTn), .en(rsp_ld), .d(rsp_err_d), .q(mem_slvRsp_err)
    );

    mem_bank_align #(.DW(DW), .SRAM_AW(SRAM_AW)) u_align (
        .addr       (mem_addr[OW+SRAM_AW:0]),
        .data_w     (mem_data_w),
        .wstrb      (mem_wstrb),
        .wen        (mem_wen),
        .even_row   (even_row),
        .odd_row    (odd_row),
        .even_wdata (even_wdata),
        .odd_wdata  (odd_wdata),
        .even_wstrb (even_wstrb),
        .odd_wstrb  (odd_wstrb),
        .rd_bsel    (rd_bsel_q),
        .rd_off     (rd_off_q),
        .even_rdata (even_rdata),
        .odd_rdata  (odd_rdata),
        .rdata      (align_rdata)
    );

    gen_sram #(.DW(DW), .AW(SRAM_AW)) u_bank_even (
        .clk   (CLK),
        .en    (bank_en),
        .wstrb (even_wstrb),
        .addr  (even_row),
        .wdata (even_wdata),
        .rdata (even_rdata)
    );

    gen_sram #(.DW(DW), .AW(SRAM_AW)) u_bank_odd (
        .clk   (CLK),
        .en    (bank_en),
        .wstrb (odd_wstrb),
        .addr  (odd_row),
        .wdata (odd_wdata),
        .rdata (odd_rdata)
    );

    always_comb begin
        state_d          = state_q;
        mem_mstReq_ready = 1'b0;
        mem_slvRsp_valid = 1'b0;
        per_req_valid    = 1'b0;
        rsp_ld           = 1'b0;
        rsp_data_d       = '0;
        rsp_err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_mstReq_ready = 1'b1;
                if (mem_mstReq_valid) begin
                    if (is_sram) begin
                        state_d = ST_SRAM_RD;
                    end else if (is_per) begin
                        state_d = ST_PER_REQ;
                    end else begin
                        rsp_ld    = 1'b1;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RSP;
                    end
                end
            end
            ST_SRAM_RD: begin
                rsp_ld     = 1'b1;
                rsp_data_d = rd_wen_q ? '0 : align_rdata;
                state_d    = ST_RSP;
            end
            ST_PER_REQ: begin
                per_req_valid = 1'b1;
                if (per_req_ready) begin
                    state_d = ST_PER_WAIT;
                end
            end
            ST_PER_WAIT: begin
                if (per_rsp_valid) begin
                    rsp_ld     = 1'b1;
                    rsp_data_d = per_wen ? '0 : per_data_r;
                    rsp_err_d  = per_rsp_err;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                mem_slvRsp_valid = 1'b1;
                if (mem_slvRsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_region_bus.sv
// tb/tb_mem_region_bus.sv - self-checking bench for mem_region_bus with a byte-array reference model
module tb_mem_region_bus;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        mem_mstReq_valid;
    logic        mem_mstReq_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_data_w;
    logic [7:0]  mem_wstrb;
    logic        mem_wen;
    logic        mem_slvRsp_valid;
    logic        mem_slvRsp_ready;
    logic [63:0] mem_data_r;
    logic        mem_slvRsp_err;
    logic        per_req_valid;
    logic        per_req_ready;
    logic [63:0] per_addr;
    logic [63:0] per_data_w;
    logic [7:0]  per_wstrb;
    logic        per_wen;
    logic        per_rsp_valid;
    logic [63:0] per_data_r;
    logic        per_rsp_err;

    int total  = 0;
    int passed = 0;

    // Flat byte image of the 32 KiB SRAM window: byte k of an access lives at (addr + k) mod 32K.
    logic [7:0] mdl [32768];

    always #5 CLK = ~CLK;

    mem_region_bus #(.DW(64), .SRAM_AW(11)) dut (
        .CLK              (CLK),
        .RSTn             (RSTn),
        .mem_mstReq_valid (mem_mstReq_valid),
        .mem_mstReq_ready (mem_mstReq_ready),
        .mem_addr         (mem_addr),
        .mem_data_w       (mem_data_w),
        .mem_wstrb        (mem_wstrb),
        .mem_wen          (mem_wen),
        .mem_slvRsp_valid (mem_slvRsp_valid),
        .mem_slvRsp_ready (mem_slvRsp_ready),
        .mem_data_r       (mem_data_r),
        .mem_slvRsp_err   (mem_slvRsp_err),
        .per_req_valid    (per_req_valid),
        .per_req_ready    (per_req_ready),
        .per_addr         (per_addr),
        .per_data_w       (per_data_w),
        .per_wstrb        (per_wstrb),
        .per_wen          (per_wen),
        .per_rsp_valid    (per_rsp_valid),
        .per_data_r       (per_data_r),
        .per_rsp_err      (per_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic in_sram(input logic [63:0] a);
        return a[63:28] == 36'h8;
    endfunction

    task automatic do_req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic w, input int bp,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge CLK);
        check("req_ready", 64'(mem_mstReq_ready), 64'd1);
        mem_mstReq_valid = 1'b1;
        mem_addr         = a;
        mem_data_w       = d;
        mem_wstrb        = s;
        mem_wen          = w;
        mem_slvRsp_ready = (bp == 0);
        @(negedge CLK);
        mem_mstReq_valid = 1'b0;
        lat = 1;
        while (!mem_slvRsp_valid && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        rd = mem_data_r;
        er = mem_slvRsp_err;
        repeat (bp) @(negedge CLK);
        mem_slvRsp_ready = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_op(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic w, input string tag, output logic [63:0] rd);
        logic [63:0] exp;
        logic        er;
        int          lat;
        exp = '0;
        if (in_sram(a) && !w) begin
            for (int k = 0; k < 8; k++) exp[k*8 +: 8] = mdl[(int'(a[14:0]) + k) % 32768];
        end
        do_req(a, d, s, w, $urandom_range(0, 2), rd, er, lat);
        if (in_sram(a)) begin
            check({tag, "_lat"}, 64'(lat), 64'd2);
            check({tag, "_err"}, 64'(er), 64'd0);
            check({tag, "_data"}, rd, exp);
            if (w) begin
                for (int k = 0; k < 8; k++)
                    if (s[k]) mdl[(int'(a[14:0]) + k) % 32768] = d[k*8 +: 8];
            end
        end else begin
            check({tag, "_unm_lat"}, 64'(lat), 64'd1);
            check({tag, "_unm_err"}, 64'(er), 64'd1);
            check({tag, "_unm_data"}, rd, 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] a;
        mem_mstReq_valid = 1'b0;
        mem_addr         = '0;
        mem_data_w       = '0;
        mem_wstrb        = '0;
        mem_wen          = 1'b0;
        mem_slvRsp_ready = 1'b1;
        per_req_ready    = 1'b0;
        per_rsp_valid    = 1'b0;
        per_data_r       = '0;
        per_rsp_err      = 1'b0;
        for (int k = 0; k < 32768; k++) mdl[k] = 8'h00;

        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check("rst_req_ready", 64'(mem_mstReq_ready), 64'd1);
        check("rst_rsp_valid", 64'(mem_slvRsp_valid), 64'd0);
        check("rst_data_r", mem_data_r, 64'd0);
        check("rst_err", 64'(mem_slvRsp_err), 64'd0);
        check("rst_per_valid", 64'(per_req_valid), 64'd0);
        check("rst_per_addr", per_addr, 64'd0);
        check("rst_per_data", per_data_w, 64'd0);
        check("rst_per_strb", 64'(per_wstrb), 64'd0);
        check("rst_per_wen", 64'(per_wen), 64'd0);

        for (int k = 0; k < 32; k++)
            bus_op(64'h8000_0000 + 64'(k * 8), {$urandom, $urandom}, 8'hFF, 1'b1, "prefill", rd);
        bus_op(64'h8000_7FF0, {$urandom, $urandom}, 8'hFF, 1'b1, "prefill_top", rd);
        bus_op(64'h8000_7FF8, {$urandom, $urandom}, 8'hFF, 1'b1, "prefill_top", rd);

        bus_op(64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 1'b1, "aligned_wr", rd);
        bus_op(64'h8000_0000, 64'h0, 8'hFF, 1'b0, "aligned_rd", rd);
        check("aligned_rd_const", rd, 64'h1122_3344_5566_7788);

        bus_op(64'h8000_000C, 64'hA1A2_A3A4_A5A6_A7A8, 8'hFF, 1'b1, "mis_wr", rd);
        bus_op(64'h8000_000C, 64'h0, 8'hFF, 1'b0, "mis_rd_c", rd);
        check("mis_rd_c_const", rd, 64'hA1A2_A3A4_A5A6_A7A8);
        bus_op(64'h8000_0008, 64'h0, 8'hFF, 1'b0, "mis_rd_8", rd);
        check("mis_rd_8_upper", {32'h0, rd[63:32]}, 64'hA5A6_A7A8);

        bus_op(64'h7000_0000, 64'h0, 8'hFF, 1'b0, "unm_rd", rd);
        bus_op(64'h7000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, "unm_wr", rd);
        bus_op(64'h8000_0000, 64'h0, 8'hFF, 1'b0, "unm_nowrite", rd);
        check("unm_nowrite_const", rd, 64'h1122_3344_5566_7788);

        bus_op(64'h8000_7FFC, 64'hB1B2_B3B4_B5B6_B7B8, 8'hFF, 1'b1, "wrap_wr", rd);
        bus_op(64'h8000_7FFC, 64'h0, 8'hFF, 1'b0, "wrap_rd_top", rd);
        check("wrap_rd_top_const", rd, 64'hB1B2_B3B4_B5B6_B7B8);
        bus_op(64'h8000_0000, 64'h0, 8'hFF, 1'b0, "wrap_rd_bot", rd);
        check("wrap_rd_bot_const", rd, 64'h1122_3344_B1B2_B3B4);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) a = 64'h8000_0000 + 64'($urandom_range(0, 248));
            else a = {32'h0000_0001, $urandom};
            bus_op(a, {$urandom, $urandom}, 8'($urandom), 1'($urandom), "rand", rd);
        end

        // Peripheral read with request and response backpressure.
        @(negedge CLK);
        mem_mstReq_valid = 1'b1;
        mem_addr         = 64'h9000_0010;
        mem_data_w       = 64'h5555;
        mem_wstrb        = 8'hFF;
        mem_wen          = 1'b0;
        per_req_ready    = 1'b0;
        @(negedge CLK);
        mem_mstReq_valid = 1'b0;
        check("per_valid_t1", 64'(per_req_valid), 64'd1);
        check("per_addr_t1", per_addr, 64'h9000_0010);
        check("per_wen_t1", 64'(per_wen), 64'd0);
        repeat (2) begin
            @(negedge CLK);
            check("per_valid_held", 64'(per_req_valid), 64'd1);
            check("per_addr_held", per_addr, 64'h9000_0010);
            check("per_mst_ready", 64'(mem_mstReq_ready), 64'd0);
        end
        @(negedge CLK);
        per_req_ready = 1'b1;
        @(negedge CLK);
        per_req_ready = 1'b0;
        check("per_wait_valid", 64'(per_req_valid), 64'd0);
        @(negedge CLK);
        check("per_wait_rsp", 64'(mem_slvRsp_valid), 64'd0);
        per_rsp_valid    = 1'b1;
        per_data_r       = 64'hDEAD_BEEF;
        per_rsp_err      = 1'b1;
        mem_slvRsp_ready = 1'b0;
        @(negedge CLK);
        per_rsp_valid = 1'b0;
        per_data_r    = 64'h0;
        per_rsp_err   = 1'b0;
        repeat (4) begin
            check("bp_valid", 64'(mem_slvRsp_valid), 64'd1);
            check("bp_data", mem_data_r, 64'hDEAD_BEEF);
            check("bp_err", 64'(mem_slvRsp_err), 64'd1);
            check("bp_mst_ready", 64'(mem_mstReq_ready), 64'd0);
            @(negedge CLK);
        end
        mem_slvRsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_done_valid", 64'(mem_slvRsp_valid), 64'd0);
        check("bp_done_ready", 64'(mem_mstReq_ready), 64'd1);

        // Peripheral write, slave accepts and responds in the same PER_REQ cycle.
        @(negedge CLK);
        mem_mstReq_valid = 1'b1;
        mem_addr         = 64'h9000_0020;
        mem_data_w       = 64'h0102_0304_0506_0708;
        mem_wstrb        = 8'h0F;
        mem_wen          = 1'b1;
        per_req_ready    = 1'b1;
        per_rsp_valid    = 1'b1;
        per_data_r       = 64'hFFFF_FFFF_FFFF_FFFF;
        per_rsp_err      = 1'b1;
        @(negedge CLK);
        mem_mstReq_valid = 1'b0;
        check("pw_valid", 64'(per_req_valid), 64'd1);
        check("pw_data", per_data_w, 64'h0102_0304_0506_0708);
        check("pw_strb", 64'(per_wstrb), 64'h0F);
        check("pw_wen", 64'(per_wen), 64'd1);
        check("pw_no_early_rsp", 64'(mem_slvRsp_valid), 64'd0);
        @(negedge CLK);
        per_req_ready = 1'b0;
        check("pw_wait_rsp", 64'(mem_slvRsp_valid), 64'd0);
        @(negedge CLK);
        per_rsp_valid = 1'b0;
        per_rsp_err   = 1'b0;
        check("pw_rsp_valid", 64'(mem_slvRsp_valid), 64'd1);
        check("pw_rsp_data", mem_data_r, 64'd0);
        check("pw_rsp_err", 64'(mem_slvRsp_err), 64'd1);
        @(posedge CLK);
        #1;

        // Reset while waiting on the peripheral response.
        @(negedge CLK);
        mem_mstReq_valid = 1'b1;
        mem_addr         = 64'h9000_0030;
        mem_wen          = 1'b0;
        per_req_ready    = 1'b1;
        @(negedge CLK);
        mem_mstReq_valid = 1'b0;
        check("rw_per_valid", 64'(per_req_valid), 64'd1);
        @(negedge CLK);
        per_req_ready = 1'b0;
        check("rw_in_wait", 64'(per_req_valid), 64'd0);
        #2;
        RSTn = 1'b0;
        #1;
        check("rw_rsp_valid", 64'(mem_slvRsp_valid), 64'd0);
        check("rw_per_valid0", 64'(per_req_valid), 64'd0);
        check("rw_per_addr0", per_addr, 64'd0);
        check("rw_data_r0", mem_data_r, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        check("rw_mst_ready", 64'(mem_mstReq_ready), 64'd1);
        per_rsp_valid = 1'b1;
        per_data_r    = 64'h1234;
        @(negedge CLK);
        per_rsp_valid = 1'b0;
        check("rw_stray_rsp", 64'(mem_slvRsp_valid), 64'd0);
        check("rw_stray_ready", 64'(mem_mstReq_ready), 64'd1);

        bus_op(64'h8000_7FFC, 64'h0, 8'hFF, 1'b0, "post_rst_rd", rd);
        check("post_rst_const", rd, 64'hB1B2_B3B4_B5B6_B7B8);
        for (int k = 0; k < 8; k++)
            bus_op(64'h8000_0000 + 64'($urandom_range(0, 248)), 64'h0, 8'hFF, 1'b0, "post_rst_rand", rd);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
